uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Serial transmit engine for the UART transmit path. It drains bytes from the transmit FIFO and shifts each one out on `tx_out` as a standard asynchronous frame: start bit, `dbit` data bits LSB first, optional parity bit, then stop bit(s). Bit timing is derived from the shared 16x-oversampled `baud_tick`, the same tick the receiver uses. It sits between the Tx FIFO read port and the `tx_out` pin inside the UART top.

## Interface
Parameters:
- `dbit`, 8: data bits per frame; legal range 5..8.
- `stick`, 16: baud ticks in the stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `parity_en`, 0: 1 inserts a parity bit after the MSB.
- `parity_odd`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `parity_en` = 0.

Ports:
- `clk`  in  1  system clock. This block uses one clock only.
- `rst`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-cycle pulse at 16x the baud rate.
- `fifo_empty`  in  1  Tx FIFO empty flag.
- `fifo_data`  in  `dbit`  Tx FIFO read data; valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1  one-cycle pop request to the Tx FIFO.
- `tx_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop period.

## Operation
States: IDLE, LOAD, START, DATA, PARITY, STOP.

Registers:
- `s` is a 5-bit tick counter.
- `n` is a 3-bit data-bit counter.
- `sh` is a `dbit`-wide shift register.
- `par` is 1 bit.

State transitions:
- IDLE: `tx_out` = 1. `fifo_rd` = (state == IDLE) & ~`fifo_empty` & ~`rst`; this is the only combinational output. When `fifo_rd` is asserted, go to LOAD.
- LOAD: capture `fifo_data` into `sh`. Set `par` = XOR of the data bits, XOR `parity_odd`. Clear `s` and `n`. Go to START.
- START: `tx_out` = 0. On each `baud_tick`, increment `s`. On the tick where `s` == 15, clear `s` and go to DATA.
- DATA: `tx_out` = `sh[0]`. On the tick where `s` == 15:
  - clear `s` and shift `sh` right;
  - if `n` == `dbit`-1, go to PARITY when `parity_en` = 1, otherwise go to STOP;
  - otherwise increment `n`.
- PARITY: `tx_out` = `par`. After 16 ticks, go to STOP.
- STOP: `tx_out` = 1. On the tick where `s` == `stick`-1, pulse `tx_done` and go to IDLE.

Output and arithmetic rules:
- `tx_out` is registered. It reflects the new state one cycle after each transition.
- The counter `s` is wide enough for `stick` up to 32. The counter `n` never exceeds `dbit`-1.
- Ticks arriving in IDLE or LOAD are ignored.

Reset:
- Reset values: state IDLE, `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_rd` = 0, and `s`, `n`, `sh`, `par` all 0.
- Reset asserted mid-frame aborts the frame. `tx_out` is 1 on the next cycle.
- A byte already popped from the FIFO is discarded; it is not re-queued.

## Timing
- Pop to line low takes 3 clocks: `fifo_rd` cycle, then LOAD, then `tx_out` = 0.
- Start bit duration is 16 ticks, measured from the first tick after entering START. The first bit therefore lasts between 15 and 16 tick periods.
- Every data bit and the parity bit last exactly 16 ticks. The stop period lasts `stick` ticks.
- Frame length in ticks is 16·(1 + `dbit` + `parity_en`) + `stick`. For 8N1 this is 160 ticks.
- `tx_done` and the return to IDLE occur in the same cycle.
- Back-to-back frames:
  - If `fifo_empty` = 0 in IDLE, `fifo_rd` asserts in the first IDLE cycle.
  - The next start bit begins 3 clocks after the stop period ends, with no extra idle bit time.
- `baud_tick` arriving in the same cycle as a state transition is consumed by the old state only.
- `fifo_rd` is never asserted while `fifo_empty` = 1. It is asserted at most once per frame.

## Test plan
All scenarios use `baud_tick` every 4 clocks.

1. **8N1 byte.** Load the FIFO with 0xA5; default parameters. Required response:
   - exactly one `fifo_rd` pulse;
   - line sequence 0,1,0,1,0,0,1,0,1,1, with each bit 16 ticks (64 clocks) apart;
   - one `tx_done` pulse, 160 ticks after the start;
   - `tx_busy` low afterwards.
2. **Even parity.** `parity_en` = 1, `parity_odd` = 0, byte 0x5A. Required: the parity bit is 0 and sits between the MSB and the stop bit. With `parity_odd` = 1 and byte 0x01, the parity bit is 0.
3. **Back-to-back.** FIFO holds 0x12 and 0x34. Required:
   - two frames;
   - the second start bit falls 3 clocks after the first `tx_done`;
   - two `fifo_rd` pulses and two `tx_done` pulses in total.
4. **Empty FIFO.** `fifo_empty` held at 1 for 1000 clocks with ticks running. Required: `tx_out` stays 1, and `fifo_rd`, `tx_busy` and `tx_done` stay 0.
5. **Reset mid-frame.** Assert `rst` for 1 clock during data bit 3 of 0xFF. Required:
   - `tx_out` = 1 and `tx_busy` = 0 on the next cycle;
   - no `tx_done` pulse;
   - the next FIFO byte is sent as a complete frame.
6. **Two stop bits.** `stick` = 32, two queued bytes. Required: the stop period is 32 ticks (128 clocks) before the next start bit, with `tx_out` high throughout.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit engine: pops Tx FIFO bytes and serialises them on tx_out
module uart_tx_ctrl #(
    parameter int dbit       = 8,
    parameter int stick      = 16,
    parameter int parity_en  = 0,
    parameter int parity_odd = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    input  logic            fifo_empty,
    input  logic [dbit-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx_out,
    output logic            tx_busy,
    output logic            tx_done
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] STOP_LAST = 5'(stick - 1);
    localparam logic [2:0] N_LAST    = 3'(dbit - 1);
    localparam logic       PAR_ON    = (parity_en != 0);
    localparam logic       PAR_ODD   = (parity_odd != 0);

    state_t            state, state_next;
    logic [4:0]        s, s_next;
    logic [2:0]        n, n_next;
    logic [dbit-1:0]   sh, sh_next;
    logic              par, par_next;
    logic              tx_next;
    logic              done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            sh      <= '0;
            par     <= 1'b0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_next;
            s       <= s_next;
            n       <= n_next;
            sh      <= sh_next;
            par     <= par_next;
            tx_out  <= tx_next;
            tx_busy <= (state_next != IDLE);
            tx_done <= done_next;
        end
    end

    // A tick in the cycle of a transition is consumed by the old state only.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        sh_next    = sh;
        par_next   = par;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_rd) state_next = LOAD;
            end
            LOAD: begin
                sh_next    = fifo_data;
                par_next   = (^fifo_data) ^ PAR_ODD;
                s_next     = '0;
                n_next     = '0;
                state_next = START;
            end
            START: begin
                if (baud_tick) begin
                    if (s == 5'd15) begin
                        s_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (s == 5'd15) begin
                        s_next  = '0;
                        sh_next = sh >> 1;
                        if (n == N_LAST) state_next = PAR_ON ? PARITY : STOP;
                        else             n_next     = n + 3'd1;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (s == 5'd15) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (s == STOP_LAST) begin
                        s_next     = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_next is the line level for the current state; it lands on tx_out one cycle later.
    always_comb begin
        fifo_rd = (state == IDLE) & ~fifo_empty & ~rst;
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh[0];
            PARITY:  tx_next = par;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl (8N1, 8E1, 8O1 and 8N2 instances)
module tb_uart_tx_ctrl;

    localparam int MAXC = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [3:0] fifo_empty, fifo_rd, tx_out, tx_busy, tx_done;
    logic [7:0] fifo_data [4] = '{default: 8'h00};
    logic [7:0] mem [4][16];
    logic [3:0] wr_ptr [4] = '{default: 4'd0};
    logic [3:0] rd_ptr [4] = '{default: 4'd0};

    logic tx_h   [4][MAXC];
    logic rd_h   [4][MAXC];
    logic busy_h [4][MAXC];
    logic done_h [4][MAXC];
    logic tick_h [MAXC];

    int cyc    = 0;
    int ph     = 0;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl u0 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx_ctrl #(.parity_en(1)) u1 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx_ctrl #(.parity_en(1), .parity_odd(1)) u2 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo_empty(fifo_empty[2]),
        .fifo_data(fifo_data[2]), .fifo_rd(fifo_rd[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx_ctrl #(.stick(32)) u3 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo_empty(fifo_empty[3]),
        .fifo_data(fifo_data[3]), .fifo_rd(fifo_rd[3]), .tx_out(tx_out[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    // FIFO model: data appears the cycle after a pop
    always_comb begin
        for (int i = 0; i < 4; i++) fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd[i]) begin
                fifo_data[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i]    <= rd_ptr[i] + 4'd1;
            end
        end
    end

    // Trace index c holds the outputs of cycle c and the tick consumed at the end of it.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            for (int i = 0; i < 4; i++) begin
                tx_h[i][cyc]   = tx_out[i];
                rd_h[i][cyc]   = fifo_rd[i];
                busy_h[i][cyc] = tx_busy[i];
                done_h[i][cyc] = tx_done[i];
            end
            tick_h[cyc] = baud_tick;
        end
        cyc = cyc + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            baud_tick = (ph == 0);
        end
    end

    function automatic logic sig_at(int kind, int i, int c);
        if (c < 0 || c >= MAXC || c >= cyc) return 1'bx;
        case (kind)
            0:       return tx_h[i][c];
            1:       return rd_h[i][c];
            2:       return busy_h[i][c];
            default: return done_h[i][c];
        endcase
    endfunction

    function automatic int count_high(int kind, int i, int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (sig_at(kind, i, c) === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_ticks(int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (c >= 0 && c < MAXC && c < cyc && tick_h[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int find_first(int kind, int i, int a, int b);
        for (int c = a; c <= b; c++) if (sig_at(kind, i, c) === 1'b1) return c;
        return -1;
    endfunction

    function automatic int find_start(int i, int a, int b);
        for (int c = a; c <= b; c++)
            if (sig_at(0, i, c - 1) === 1'b1 && sig_at(0, i, c) === 1'b0) return c;
        return -1;
    endfunction

    // Expected frame: start, data LSB first, optional parity; positions past the frame read as idle 1s.
    function automatic logic [15:0] frame_model(logic [7:0] d, int pe, int po);
        logic [15:0] v = 16'hFFFF;
        int ones = 0;
        v[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v[k+1] = d[k];
            if (d[k]) ones++;
        end
        if (pe != 0) v[9] = ((ones + po) % 2 == 1);
        return v;
    endfunction

    function automatic logic [15:0] decode(int i, int t0, int nb);
        logic [15:0] v = 16'hFFFF;
        for (int k = 0; k < nb; k++) v[k] = sig_at(0, i, t0 + 64 * k + 32);
        return v;
    endfunction

    // Each bit is 16 ticks = 64 clocks; the window skips the few clocks of tick-phase jitter.
    function automatic logic bits_stable(int i, int t0, int nb);
        for (int k = 0; k < nb; k++) begin
            int h = count_high(0, i, t0 + 64 * k + 1, t0 + 64 * k + 59);
            if (h != 0 && h != 59) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push(int i, logic [7:0] d);
        mem[i][wr_ptr[i]] = d;
        wr_ptr[i] = wr_ptr[i] + 4'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_out !== 4'hF)     $display("FAIL reset_tx_out got %h exp f", tx_out);     else passed++;
        total++; if (tx_busy !== 4'h0)    $display("FAIL reset_tx_busy got %h exp 0", tx_busy);   else passed++;
        total++; if (tx_done !== 4'h0)    $display("FAIL reset_tx_done got %h exp 0", tx_done);   else passed++;
        total++; if (fifo_rd !== 4'h0)    $display("FAIL reset_fifo_rd got %h exp 0", fifo_rd);   else passed++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_8n1();
        int a, b, r, t0, td;
        logic [15:0] got;
        a = cyc;
        push(0, 8'hA5);
        repeat (800) @(posedge clk);
        #1;
        b = cyc - 1;
        r = find_first(1, 0, a, b);
        t0 = find_start(0, a, b);
        td = find_first(3, 0, t0, b);
        got = decode(0, t0, 9);
        total++; if (count_high(1, 0, a, b) != 1) $display("FAIL 8n1_rd_count got %0d exp 1", count_high(1, 0, a, b)); else passed++;
        total++; if (t0 - r != 3) $display("FAIL 8n1_pop_to_low got %0d exp 3", t0 - r); else passed++;
        total++; if (got !== frame_model(8'hA5, 0, 0)) $display("FAIL 8n1_bits got %h exp %h", got, frame_model(8'hA5, 0, 0)); else passed++;
        total++; if (bits_stable(0, t0, 9) !== 1'b1) $display("FAIL 8n1_bit_width got 0 exp 1"); else passed++;
        total++; if (count_high(3, 0, a, b) != 1) $display("FAIL 8n1_done_count got %0d exp 1", count_high(3, 0, a, b)); else passed++;
        total++; if (count_ticks(t0 - 1, td - 1) != 160) $display("FAIL 8n1_frame_ticks got %0d exp 160", count_ticks(t0 - 1, td - 1)); else passed++;
        total++; if (count_high(0, 0, t0 + 577, td) != td - t0 - 576) $display("FAIL 8n1_stop_high got %0d exp %0d", count_high(0, 0, t0 + 577, td), td - t0 - 576); else passed++;
        total++; if (busy_h[0][b] !== 1'b0) $display("FAIL 8n1_busy_after got %b exp 0", busy_h[0][b]); else passed++;
    endtask

    task automatic test_parity();
        int a, b, t0, td;
        logic [7:0] d [3] = '{8'h00, 8'h5A, 8'h01};
        logic [15:0] got;
        a = cyc;
        push(1, d[1]);
        push(2, d[2]);
        repeat (800) @(posedge clk);
        #1;
        b = cyc - 1;
        for (int i = 1; i <= 2; i++) begin
            t0 = find_start(i, a, b);
            td = find_first(3, i, t0, b);
            got = decode(i, t0, 10);
            total++; if (got !== frame_model(d[i], 1, i - 1)) $display("FAIL parity%0d_bits got %h exp %h", i, got, frame_model(d[i], 1, i - 1)); else passed++;
            total++; if (got[9] !== 1'b0) $display("FAIL parity%0d_bit got %b exp 0", i, got[9]); else passed++;
            total++; if (bits_stable(i, t0, 10) !== 1'b1) $display("FAIL parity%0d_bit_width got 0 exp 1", i); else passed++;
            total++; if (count_ticks(t0 - 1, td - 1) != 176) $display("FAIL parity%0d_frame_ticks got %0d exp 176", i, count_ticks(t0 - 1, td - 1)); else passed++;
            total++; if (count_high(0, i, t0 + 641, td) != td - t0 - 640) $display("FAIL parity%0d_stop_high got %0d exp %0d", i, count_high(0, i, t0 + 641, td), td - t0 - 640); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int a, b, t0, td0, t1, td1;
        logic [15:0] got0, got1;
        a = cyc;
        push(0, 8'h12);
        push(0, 8'h34);
        repeat (1500) @(posedge clk);
        #1;
        b = cyc - 1;
        t0  = find_start(0, a, b);
        td0 = find_first(3, 0, t0, b);
        t1  = find_start(0, td0, b);
        td1 = find_first(3, 0, t1, b);
        got0 = decode(0, t0, 9);
        got1 = decode(0, t1, 9);
        total++; if (count_high(1, 0, a, b) != 2) $display("FAIL b2b_rd_count got %0d exp 2", count_high(1, 0, a, b)); else passed++;
        total++; if (count_high(3, 0, a, b) != 2) $display("FAIL b2b_done_count got %0d exp 2", count_high(3, 0, a, b)); else passed++;
        total++; if (got0 !== frame_model(8'h12, 0, 0)) $display("FAIL b2b_bits0 got %h exp %h", got0, frame_model(8'h12, 0, 0)); else passed++;
        total++; if (t1 - td0 != 3) $display("FAIL b2b_gap got %0d exp 3", t1 - td0); else passed++;
        total++; if (got1 !== frame_model(8'h34, 0, 0)) $display("FAIL b2b_bits1 got %h exp %h", got1, frame_model(8'h34, 0, 0)); else passed++;
        total++; if (count_ticks(t1 - 1, td1 - 1) != 160) $display("FAIL b2b_frame1_ticks got %0d exp 160", count_ticks(t1 - 1, td1 - 1)); else passed++;
    endtask

    task automatic test_empty();
        int a, b;
        a = cyc;
        repeat (1000) @(posedge clk);
        #1;
        b = cyc - 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (count_high(0, i, a, b) != b - a + 1) $display("FAIL empty%0d_tx_high got %0d exp %0d", i, count_high(0, i, a, b), b - a + 1); else passed++;
            total++; if (count_high(1, i, a, b) != 0) $display("FAIL empty%0d_rd got %0d exp 0", i, count_high(1, i, a, b)); else passed++;
            total++; if (count_high(2, i, a, b) != 0) $display("FAIL empty%0d_busy got %0d exp 0", i, count_high(2, i, a, b)); else passed++;
            total++; if (count_high(3, i, a, b) != 0) $display("FAIL empty%0d_done got %0d exp 0", i, count_high(3, i, a, b)); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int a, b, t0, rc, r1, t1, td1;
        logic [15:0] got;
        a = cyc;
        push(0, 8'hFF);
        push(0, 8'h3C);
        repeat (10) @(posedge clk);
        #1;
        t0 = find_start(0, a, cyc - 1);
        while (cyc < t0 + 64 * 4 + 32 && cyc < a + 600) @(posedge clk);
        #1;
        total++; if (tx_busy[0] !== 1'b1) $display("FAIL rstmid_busy_before got %b exp 1", tx_busy[0]); else passed++;
        rst = 1'b1;
        rc = cyc;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (tx_out[0] !== 1'b1)  $display("FAIL rstmid_tx_out got %b exp 1", tx_out[0]);   else passed++;
        total++; if (tx_busy[0] !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", tx_busy[0]);   else passed++;
        repeat (800) @(posedge clk);
        #1;
        b = cyc - 1;
        r1  = find_first(1, 0, rc, b);
        t1  = find_start(0, rc, b);
        td1 = find_first(3, 0, t1, b);
        got = decode(0, t1, 9);
        total++; if (count_high(3, 0, a, t1) != 0) $display("FAIL rstmid_no_done got %0d exp 0", count_high(3, 0, a, t1)); else passed++;
        total++; if (count_high(1, 0, a, b) != 2) $display("FAIL rstmid_rd_count got %0d exp 2", count_high(1, 0, a, b)); else passed++;
        total++; if (t1 - r1 != 3) $display("FAIL rstmid_pop_to_low got %0d exp 3", t1 - r1); else passed++;
        total++; if (got !== frame_model(8'h3C, 0, 0)) $display("FAIL rstmid_next_bits got %h exp %h", got, frame_model(8'h3C, 0, 0)); else passed++;
        total++; if (count_ticks(t1 - 1, td1 - 1) != 160) $display("FAIL rstmid_next_ticks got %0d exp 160", count_ticks(t1 - 1, td1 - 1)); else passed++;
    endtask

    task automatic test_two_stop();
        int a, b, t0, td0, t1, td1;
        logic [7:0]  d0, d1;
        logic [15:0] got0, got1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        a = cyc;
        push(3, d0);
        push(3, d1);
        repeat (1600) @(posedge clk);
        #1;
        b = cyc - 1;
        t0  = find_start(3, a, b);
        td0 = find_first(3, 3, t0, b);
        t1  = find_start(3, td0, b);
        td1 = find_first(3, 3, t1, b);
        got0 = decode(3, t0, 9);
        got1 = decode(3, t1, 9);
        total++; if (got0 !== frame_model(d0, 0, 0)) $display("FAIL stop2_bits0 got %h exp %h", got0, frame_model(d0, 0, 0)); else passed++;
        total++; if (count_ticks(t0 - 1, td0 - 1) != 176) $display("FAIL stop2_frame0_ticks got %0d exp 176", count_ticks(t0 - 1, td0 - 1)); else passed++;
        total++; if (count_high(0, 3, t0 + 577, t1 - 1) != t1 - t0 - 577) $display("FAIL stop2_line_high got %0d exp %0d", count_high(0, 3, t0 + 577, t1 - 1), t1 - t0 - 577); else passed++;
        total++; if (t1 - td0 != 3) $display("FAIL stop2_gap got %0d exp 3", t1 - td0); else passed++;
        total++; if (got1 !== frame_model(d1, 0, 0)) $display("FAIL stop2_bits1 got %h exp %h", got1, frame_model(d1, 0, 0)); else passed++;
        total++; if (count_ticks(t1 - 1, td1 - 1) != 176) $display("FAIL stop2_frame1_ticks got %0d exp 176", count_ticks(t1 - 1, td1 - 1)); else passed++;
        total++; if (count_high(3, 3, a, b) != 2) $display("FAIL stop2_done_count got %0d exp 2", count_high(3, 3, a, b)); else passed++;
    endtask

    task automatic test_random_bytes();
        int a, b, t0, td;
        logic [7:0]  d [3];
        logic [15:0] got;
        for (int round = 0; round < 2; round++) begin
            a = cyc;
            for (int i = 0; i < 3; i++) begin
                d[i] = 8'($urandom);
                push(i, d[i]);
            end
            repeat (800) @(posedge clk);
            #1;
            b = cyc - 1;
            for (int i = 0; i < 3; i++) begin
                int pe = (i == 0) ? 0 : 1;
                t0  = find_start(i, a, b);
                td  = find_first(3, i, t0, b);
                got = decode(i, t0, 9 + pe);
                total++; if (got !== frame_model(d[i], pe, (i == 2) ? 1 : 0)) $display("FAIL rand%0d_u%0d_bits data %h got %h exp %h", round, i, d[i], got, frame_model(d[i], pe, (i == 2) ? 1 : 0)); else passed++;
                total++; if (count_ticks(t0 - 1, td - 1) != 160 + 16 * pe) $display("FAIL rand%0d_u%0d_ticks got %0d exp %0d", round, i, count_ticks(t0 - 1, td - 1), 160 + 16 * pe); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_empty();
        test_reset_mid_frame();
        test_two_stop();
        test_random_bytes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
